// File: rtl/insn_pipe_tracker_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the instruction-tracking pipeline: RV32 major opcodes,
// instruction field bit positions, and register-usage decode helpers.
// Optional feature macro used by the top: PIPE_PERF_CNT_EN.
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_NOP    = 7'b0000000;

  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int F7_LSB  = 25;

  // rs1 is read by every format except U-type, JAL and the bubble.
  function automatic logic uses_rs1(input logic [6:0] op);
    case (op)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_NOP: return 1'b0;
      OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_OP,
      OPC_OP_IMM, OPC_JALR, OPC_SYSTEM:     return 1'b1;
      default:                              return 1'b1;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OPC_OP) || (op == OPC_STORE) || (op == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/insn_pipe_tracker_if.sv
// -----------------------------------------------------------------------------
// insn_pipe_tracker_if
// Fetch-side handshake between the fetch unit (master) and the tracker (slave).
//   fetch_valid : insn_f/pc_f valid this cycle          (master -> slave)
//   insn_f      : fetched instruction                    (master -> slave)
//   pc_f        : PC of insn_f                           (master -> slave)
//   fetch_ready : tracker accepts; low holds PC and insn (slave -> master)
// -----------------------------------------------------------------------------
interface insn_pipe_tracker_if #(
  parameter int DATAW = 32,
  parameter int PCW   = 32
) ();
  logic             fetch_valid;
  logic             fetch_ready;
  logic [DATAW-1:0] insn_f;
  logic [PCW-1:0]   pc_f;

  modport master (output fetch_valid, output insn_f, output pc_f, input  fetch_ready);
  modport slave  (input  fetch_valid, input  insn_f, input  pc_f, output fetch_ready);
endinterface

// File: rtl/insn_pipe_tracker_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Combinational load-use hazard detection and D/X bubble request.
//   insn_d    : instruction in D (already zeroed when F/D is invalid)
//   opcode_dx : opcode held in D/X
//   rd_dx     : rd held in D/X
//   pc_sel    : taken branch/jump resolved in X
//   stall     : load-use stall (suppressed by a flush)
//   bubble_dx : D/X loads a NOP on the next edge
// -----------------------------------------------------------------------------
module hazard_detect
  import pipe_pkg::*;
#(
  parameter int DATAW = 32,
  parameter int ADDRW = $clog2(DATAW)
) (
  input  logic [DATAW-1:0] insn_d,
  input  logic [6:0]       opcode_dx,
  input  logic [ADDRW-1:0] rd_dx,
  input  logic             pc_sel,
  output logic             stall,
  output logic             bubble_dx
);

  logic [6:0]       w_op_d;
  logic [ADDRW-1:0] w_rs1_d;
  logic [ADDRW-1:0] w_rs2_d;
  logic             w_hazard;
  logic             w_unused_bits;

  assign w_op_d  = insn_d[OPC_LSB +: 7];
  assign w_rs1_d = insn_d[RS1_LSB +: ADDRW];
  assign w_rs2_d = insn_d[RS2_LSB +: ADDRW];
  assign w_unused_bits = ^{insn_d[DATAW-1:RS2_LSB+ADDRW], insn_d[RS1_LSB-1:OPC_LSB+7]};

  // x0 is never a real dependency, hence the rd_dx != 0 term.
  assign w_hazard = (opcode_dx == OPC_LOAD) && (rd_dx != '0) &&
                    ((uses_rs1(w_op_d) && (w_rs1_d == rd_dx)) ||
                     (uses_rs2(w_op_d) && (w_rs2_d == rd_dx)));

  // A flush squashes the dependent insn anyway, so it wins over the stall.
  assign stall     = w_hazard && !pc_sel;
  assign bubble_dx = stall || pc_sel;

endmodule

// File: rtl/insn_pipe_tracker.sv
// -----------------------------------------------------------------------------
// insn_pipe_tracker
// Tracks instructions F/D -> D/X -> X/M -> M/W for the control-signal block.
// Bubble = opcode 0, rd 0 (downstream treats as NOP).
// Ports:
//   clock, reset_n      : rising-edge clock, async active-low reset
//   fetch (slave)       : fetch_valid/insn_f/pc_f in, fetch_ready out
//   pc_sel              : taken branch/jump resolved in X (flush)
//   funct3/funct7/pc_d  : D-stage fields of the insn in F/D
//   opcode_dx, addr_rs1_dx, addr_rs2_dx : D/X stage
//   opcode_xm, addr_rd_xm               : X/M stage
//   opcode_mw, addr_rd_mw               : M/W stage
//   stall, bubble_dx    : load-use stall and D/X bubble
//   stall_cnt, flush_cnt: saturating perf counters (PIPE_PERF_CNT_EN only)
// Optional feature macro: PIPE_PERF_CNT_EN
// -----------------------------------------------------------------------------
module insn_pipe_tracker
  import pipe_pkg::*;
#(
  parameter int DATAW = 32,
  parameter int ADDRW = $clog2(DATAW),
  parameter int PCW   = 32
`ifdef PIPE_PERF_CNT_EN
  , parameter int PERF_CNTW = 32
`endif
) (
  input  logic                 clock,
  input  logic                 reset_n,
  insn_pipe_tracker_if.slave   fetch,
  input  logic                 pc_sel,
  output logic [2:0]           funct3,
  output logic [6:0]           funct7,
  output logic [PCW-1:0]       pc_d,
  output logic [6:0]           opcode_dx,
  output logic [ADDRW-1:0]     addr_rs1_dx,
  output logic [ADDRW-1:0]     addr_rs2_dx,
  output logic [6:0]           opcode_xm,
  output logic [ADDRW-1:0]     addr_rd_xm,
  output logic [6:0]           opcode_mw,
  output logic [ADDRW-1:0]     addr_rd_mw,
  output logic                 stall,
  output logic                 bubble_dx
`ifdef PIPE_PERF_CNT_EN
  , output logic [PERF_CNTW-1:0] stall_cnt
  , output logic [PERF_CNTW-1:0] flush_cnt
`endif
);

  logic             r_fd_valid;
  logic [DATAW-1:0] r_insn_d;
  logic [PCW-1:0]   r_pc_d;
  logic [6:0]       r_op_dx;
  logic [ADDRW-1:0] r_rs1_dx, r_rs2_dx, r_rd_dx;
  logic [6:0]       r_op_xm, r_op_mw;
  logic [ADDRW-1:0] r_rd_xm, r_rd_mw;

  logic [DATAW-1:0] w_insn_d;
  logic             w_stall;
  logic             w_bubble_dx;
  logic             w_fd_load;

  // An invalid F/D slot decodes as all-zero, i.e. a bubble.
  assign w_insn_d  = r_fd_valid ? r_insn_d : '0;
  assign w_fd_load = !pc_sel && !w_stall && fetch.fetch_valid;

  hazard_detect #(.DATAW(DATAW), .ADDRW(ADDRW)) u_hazard (
    .insn_d    (w_insn_d),
    .opcode_dx (r_op_dx),
    .rd_dx     (r_rd_dx),
    .pc_sel    (pc_sel),
    .stall     (w_stall),
    .bubble_dx (w_bubble_dx)
  );

  // ---- F/D stage ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fd_valid <= 1'b0;
      r_insn_d   <= '0;
    end else if (pc_sel) begin
      r_fd_valid <= 1'b0;
    end else if (!w_stall) begin
      r_fd_valid <= fetch.fetch_valid;
      if (fetch.fetch_valid) r_insn_d <= fetch.insn_f;
    end
  end

  always_ff @(posedge clock) begin
    if (w_fd_load) r_pc_d <= fetch.pc_f;
  end

  // ---- D/X stage ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_op_dx  <= OPC_NOP;
      r_rs1_dx <= '0;
      r_rs2_dx <= '0;
      r_rd_dx  <= '0;
    end else if (w_bubble_dx) begin
      r_op_dx  <= OPC_NOP;
      r_rs1_dx <= '0;
      r_rs2_dx <= '0;
      r_rd_dx  <= '0;
    end else begin
      r_op_dx  <= w_insn_d[OPC_LSB +: 7];
      r_rs1_dx <= w_insn_d[RS1_LSB +: ADDRW];
      r_rs2_dx <= w_insn_d[RS2_LSB +: ADDRW];
      r_rd_dx  <= w_insn_d[RD_LSB  +: ADDRW];
    end
  end

  // ---- X/M and M/W stages: always advance, even during a stall ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_op_xm <= OPC_NOP;
      r_rd_xm <= '0;
      r_op_mw <= OPC_NOP;
      r_rd_mw <= '0;
    end else begin
      r_op_xm <= r_op_dx;
      r_rd_xm <= r_rd_dx;
      r_op_mw <= r_op_xm;
      r_rd_mw <= r_rd_xm;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  function automatic logic [PERF_CNTW-1:0] sat_inc(input logic [PERF_CNTW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [PERF_CNTW-1:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (pc_sel)  r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

  assign fetch.fetch_ready = !w_stall;
  assign funct3      = w_insn_d[F3_LSB +: 3];
  assign funct7      = w_insn_d[F7_LSB +: 7];
  assign pc_d        = r_pc_d;
  assign opcode_dx   = r_op_dx;
  assign addr_rs1_dx = r_rs1_dx;
  assign addr_rs2_dx = r_rs2_dx;
  assign opcode_xm   = r_op_xm;
  assign addr_rd_xm  = r_rd_xm;
  assign opcode_mw   = r_op_mw;
  assign addr_rd_mw  = r_rd_mw;
  assign stall       = w_stall;
  assign bubble_dx   = w_bubble_dx;

endmodule

// File: tb/tb_insn_pipe_tracker.sv
module tb_insn_pipe_tracker;

  localparam logic [31:0] I_ADD   = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] I_SUB   = 32'h402081B3; // sub  x3,x1,x2
  localparam logic [31:0] I_LW5   = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] I_LW0   = 32'h0000A003; // lw   x0,0(x1)
  localparam logic [31:0] I_USE5  = 32'h00028333; // add  x6,x5,x0
  localparam logic [31:0] I_USE0  = 32'h00000333; // add  x6,x0,x0
  localparam logic [31:0] I_LUI5  = 32'h000282B7; // lui  x5,0x28 (rs1 field = 5)
  localparam logic [31:0] I_ADDI  = 32'h00100393; // addi x7,x0,1
  localparam logic [31:0] I_BEQ   = 32'h00208463; // beq  x1,x2,8

  logic clock = 1'b0;
  logic reset_n;
  logic pc_sel;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] pc_d;
  logic [6:0]  opcode_dx, opcode_xm, opcode_mw;
  logic [4:0]  addr_rs1_dx, addr_rs2_dx, addr_rd_xm, addr_rd_mw;
  logic        stall, bubble_dx;
`ifdef PIPE_PERF_CNT_EN
  logic [1:0]  stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  insn_pipe_tracker_if #(.DATAW(32), .PCW(32)) fif ();

  insn_pipe_tracker #(
    .DATAW(32), .PCW(32)
`ifdef PIPE_PERF_CNT_EN
    , .PERF_CNTW(2)
`endif
  ) dut (
    .clock(clock), .reset_n(reset_n), .fetch(fif), .pc_sel(pc_sel),
    .funct3(funct3), .funct7(funct7), .pc_d(pc_d),
    .opcode_dx(opcode_dx), .addr_rs1_dx(addr_rs1_dx), .addr_rs2_dx(addr_rs2_dx),
    .opcode_xm(opcode_xm), .addr_rd_xm(addr_rd_xm),
    .opcode_mw(opcode_mw), .addr_rd_mw(addr_rd_mw),
    .stall(stall), .bubble_dx(bubble_dx)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] insn, input logic [31:0] pc);
    fif.fetch_valid = v;
    fif.insn_f      = insn;
    fif.pc_f        = pc;
  endtask

  task automatic flush_pipe();
    drive(1'b0, 32'h0, 32'h0);
    pc_sel = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    pc_sel  = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #2;
    checks++; if (opcode_dx !== 7'h00) begin failures++; $display("FAIL rst_opcode_dx got=%h exp=00", opcode_dx); end
    checks++; if (opcode_xm !== 7'h00) begin failures++; $display("FAIL rst_opcode_xm got=%h exp=00", opcode_xm); end
    checks++; if (opcode_mw !== 7'h00) begin failures++; $display("FAIL rst_opcode_mw got=%h exp=00", opcode_mw); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", stall); end
    checks++; if (bubble_dx !== 1'b0) begin failures++; $display("FAIL rst_bubble got=%b exp=0", bubble_dx); end
    checks++; if (fif.fetch_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", fif.fetch_ready); end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_straight_line();
    drive(1'b1, I_ADD, 32'h100);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    checks++; if (pc_d !== 32'h100) begin failures++; $display("FAIL sl_pc_d got=%h exp=100", pc_d); end
    checks++; if (opcode_dx !== 7'h00) begin failures++; $display("FAIL sl_dx_c0 got=%h exp=00", opcode_dx); end
    tick();
    checks++; if (opcode_dx !== 7'h33) begin failures++; $display("FAIL sl_dx_c1 got=%h exp=33", opcode_dx); end
    checks++; if (addr_rs1_dx !== 5'd1 || addr_rs2_dx !== 5'd2) begin failures++; $display("FAIL sl_rs got=%0d,%0d exp=1,2", addr_rs1_dx, addr_rs2_dx); end
    tick();
    checks++; if (opcode_xm !== 7'h33 || addr_rd_xm !== 5'd3) begin failures++; $display("FAIL sl_xm got=%h/%0d exp=33/3", opcode_xm, addr_rd_xm); end
    checks++; if (opcode_dx !== 7'h00) begin failures++; $display("FAIL sl_dx_c2 got=%h exp=00", opcode_dx); end
    tick();
    checks++; if (opcode_mw !== 7'h33 || addr_rd_mw !== 5'd3) begin failures++; $display("FAIL sl_mw got=%h/%0d exp=33/3", opcode_mw, addr_rd_mw); end
    flush_pipe();
  endtask

  task automatic test_load_use();
    drive(1'b1, I_LW5, 32'h200);
    tick();
    drive(1'b1, I_USE5, 32'h204);
    tick();
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", stall); end
    checks++; if (bubble_dx !== 1'b1) begin failures++; $display("FAIL lu_bubble got=%b exp=1", bubble_dx); end
    checks++; if (fif.fetch_ready !== 1'b0) begin failures++; $display("FAIL lu_ready got=%b exp=0", fif.fetch_ready); end
    drive(1'b1, I_ADDI, 32'h208);
    tick();
    checks++; if (opcode_dx !== 7'h00) begin failures++; $display("FAIL lu_dx_bubble got=%h exp=00", opcode_dx); end
    checks++; if (opcode_xm !== 7'h03) begin failures++; $display("FAIL lu_xm_load got=%h exp=03", opcode_xm); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lu_one_cycle got=%b exp=0", stall); end
    checks++; if (pc_d !== 32'h204) begin failures++; $display("FAIL lu_pc_hold got=%h exp=204", pc_d); end
    tick();
    checks++; if (opcode_dx !== 7'h33 || addr_rs1_dx !== 5'd5) begin failures++; $display("FAIL lu_use_dx got=%h/%0d exp=33/5", opcode_dx, addr_rs1_dx); end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    checks++; if (opcode_dx !== 7'h13) begin failures++; $display("FAIL lu_next_dx got=%h exp=13", opcode_dx); end
    flush_pipe();
  endtask

  task automatic test_no_false_stall();
    drive(1'b1, I_LW0, 32'h300);
    tick();
    drive(1'b1, I_USE0, 32'h304);
    tick();
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL nfs_x0 got=%b exp=0", stall); end
    drive(1'b1, I_LW5, 32'h308);
    tick();
    checks++; if (opcode_dx !== 7'h33) begin failures++; $display("FAIL nfs_x0_dx got=%h exp=33", opcode_dx); end
    drive(1'b1, I_LUI5, 32'h30C);
    tick();
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL nfs_lui got=%b exp=0", stall); end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    checks++; if (opcode_dx !== 7'h37) begin failures++; $display("FAIL nfs_lui_dx got=%h exp=37", opcode_dx); end
    flush_pipe();
  endtask

  task automatic test_flush();
    drive(1'b1, I_BEQ, 32'h400);
    tick();
    drive(1'b1, I_LW5, 32'h404);
    tick();
    checks++; if (opcode_dx !== 7'h63) begin failures++; $display("FAIL fl_br_dx got=%h exp=63", opcode_dx); end
    drive(1'b1, I_SUB, 32'h408);
    pc_sel = 1'b1;
    #1;
    checks++; if (bubble_dx !== 1'b1 || stall !== 1'b0 || fif.fetch_ready !== 1'b1) begin failures++; $display("FAIL fl_ctrl got=%b%b%b exp=101", bubble_dx, stall, fif.fetch_ready); end
    tick();
    pc_sel = 1'b0;
    drive(1'b1, I_ADDI, 32'h800);
    checks++; if (opcode_dx !== 7'h00) begin failures++; $display("FAIL fl_dx got=%h exp=00", opcode_dx); end
    checks++; if (funct3 !== 3'd0 || funct7 !== 7'd0) begin failures++; $display("FAIL fl_fd_invalid got=%h/%h exp=0/0", funct3, funct7); end
    checks++; if (opcode_xm !== 7'h63) begin failures++; $display("FAIL fl_xm got=%h exp=63", opcode_xm); end
    tick();
    drive(1'b0, 32'h0, 32'h0);
    checks++; if (opcode_dx !== 7'h00) begin failures++; $display("FAIL fl_dx_next got=%h exp=00", opcode_dx); end
    checks++; if (pc_d !== 32'h800) begin failures++; $display("FAIL fl_redirect_pc got=%h exp=800", pc_d); end
    tick();
    checks++; if (opcode_dx !== 7'h13) begin failures++; $display("FAIL fl_target_dx got=%h exp=13", opcode_dx); end
    flush_pipe();
    // Flush coinciding with a load-use hazard
    drive(1'b1, I_LW5, 32'h500);
    tick();
    drive(1'b1, I_USE5, 32'h504);
    tick();
    pc_sel = 1'b1;
    drive(1'b1, I_ADDI, 32'h508);
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flh_stall got=%b exp=0", stall); end
    checks++; if (bubble_dx !== 1'b1) begin failures++; $display("FAIL flh_bubble got=%b exp=1", bubble_dx); end
    tick();
    pc_sel = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    checks++; if (opcode_dx !== 7'h00 || opcode_xm !== 7'h03) begin failures++; $display("FAIL flh_pipe got=%h/%h exp=00/03", opcode_dx, opcode_xm); end
    tick();
    checks++; if (opcode_dx !== 7'h00) begin failures++; $display("FAIL flh_squashed got=%h exp=00", opcode_dx); end
    flush_pipe();
  endtask

  task automatic test_reset_mid_traffic();
    drive(1'b1, I_ADDI, 32'h600);
    tick();
    drive(1'b1, I_LW5, 32'h604);
    tick();
    drive(1'b1, I_USE5, 32'h608);
    tick();
    checks++; if (stall !== 1'b1 || opcode_xm !== 7'h13) begin failures++; $display("FAIL rm_pre got=%b/%h exp=1/13", stall, opcode_xm); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (opcode_dx !== 7'h00 || opcode_xm !== 7'h00 || opcode_mw !== 7'h00) begin failures++; $display("FAIL rm_opcodes got=%h/%h/%h exp=0/0/0", opcode_dx, opcode_xm, opcode_mw); end
    checks++; if (stall !== 1'b0 || fif.fetch_ready !== 1'b1) begin failures++; $display("FAIL rm_ctrl got=%b/%b exp=0/1", stall, fif.fetch_ready); end
    drive(1'b0, 32'h0, 32'h0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    checks++; if (opcode_dx !== 7'h00 || stall !== 1'b0) begin failures++; $display("FAIL rm_after got=%h/%b exp=00/0", opcode_dx, stall); end
  endtask

`ifdef PIPE_PERF_CNT_EN
  task automatic test_perf();
    checks++; if (stall_cnt !== 2'd0 || flush_cnt !== 2'd0) begin failures++; $display("FAIL pf_reset got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, I_LW5, 32'h700);
      tick();
      drive(1'b1, I_USE5, 32'h704);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      repeat (3) tick();
    end
    checks++; if (stall_cnt !== 2'd3) begin failures++; $display("FAIL pf_stall3 got=%0d exp=3", stall_cnt); end
    for (int i = 0; i < 2; i++) begin
      pc_sel = 1'b1;
      tick();
      pc_sel = 1'b0;
      tick();
    end
    checks++; if (flush_cnt !== 2'd2) begin failures++; $display("FAIL pf_flush2 got=%0d exp=2", flush_cnt); end
    drive(1'b1, I_LW5, 32'h710);
    tick();
    drive(1'b1, I_USE5, 32'h714);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      pc_sel = 1'b1;
      tick();
      pc_sel = 1'b0;
      tick();
    end
    checks++; if (stall_cnt !== 2'd3) begin failures++; $display("FAIL pf_stall_sat got=%0d exp=3", stall_cnt); end
    checks++; if (flush_cnt !== 2'd3) begin failures++; $display("FAIL pf_flush_sat got=%0d exp=3", flush_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_straight_line();
    test_load_use();
    test_no_false_stall();
    test_flush();
    test_reset_mid_traffic();
`ifdef PIPE_PERF_CNT_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
